// File: rtl/divisor_pkg.sv
// divisor_pkg: shared FSM encoding and counter sizing for the restoring divider.
package divisor_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ITER = 2'd2, DONE = 2'd3} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/divisor_fd.sv
// divisor_fd: shift-subtract-restore datapath with A/Q/B registers, iteration counter and dbz flag.
module divisor_fd
  import divisor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             iter,
  input  logic             take,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic             zero,
  output logic             sub_neg,
  output logic             dbz,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);
  localparam int CW = cnt_w(WIDTH);
  // A's extra top bit is provably 0 once stored (A < B), so only WIDTH bits are kept.
  logic [WIDTH-1:0] a_q, a_d, q_q, q_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   shifted, t;
  assign shifted = {a_q, q_q[WIDTH-1]};
  assign t       = shifted - {1'b0, b_q};
  assign sub_neg = t[WIDTH];
  assign zero    = cnt_q == '0;
  assign dbz     = dbz_q;
  assign q       = q_q;
  assign r       = a_q;
  always_comb begin
    a_d   = load ? '0 : iter ? (take ? t[WIDTH-1:0] : shifted[WIDTH-1:0]) : a_q;
    q_d   = load ? n : iter ? {q_q[WIDTH-2:0], take} : q_q;
    b_d   = load ? d : b_q;
    cnt_d = load ? CW'(WIDTH - 1) : iter ? cnt_q - 1'b1 : cnt_q;
    dbz_d = load ? (d == '0) : dbz_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q   <= '0;
      q_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      q_q   <= q_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end
endmodule

// File: rtl/divisor_seq.sv
// divisor_seq: sequential unsigned restoring divider; FSM control unit driving divisor_fd.
module divisor_seq
  import divisor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] N_in,
  input  logic [WIDTH-1:0] D_in,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] Q_out,
  output logic [WIDTH-1:0] R_out
);
  state_t state_q, state_d;
  logic   zero, sub_neg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? LOAD : IDLE;
      LOAD:    state_d = ITER;
      ITER:    state_d = zero ? DONE : ITER;
      default: state_d = IDLE;
    endcase
  end
  assign busy = (state_q == LOAD) || (state_q == ITER);
  assign done = state_q == DONE;
  divisor_fd #(.WIDTH(WIDTH)) u_fd (
    .clk     (clk),
    .rst     (rst),
    .load    (state_q == LOAD),
    .iter    (state_q == ITER),
    .take    (~sub_neg),
    .n       (N_in),
    .d       (D_in),
    .zero    (zero),
    .sub_neg (sub_neg),
    .dbz     (dbz),
    .q       (Q_out),
    .r       (R_out)
  );
endmodule
